// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: state encoding, word width
// and the byte-address to word-index mapping.
package mem_pkg;

   localparam int WORD_W = 32;

   localparam logic [1:0] IDLE_ENC = 2'd0;
   localparam logic [1:0] WAIT_ENC = 2'd1;
   localparam logic [1:0] RESP_ENC = 2'd2;

   typedef enum logic [1:0] {
      IDLE = IDLE_ENC,
      WAIT = WAIT_ENC,
      RESP = RESP_ENC
   } state_e;

   // Byte address to 32-bit word index; the low two bits select a byte lane.
   function automatic logic [29:0] word_index(input logic [31:0] addr);
      return addr[31:2];
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word-wide RAM with a synchronous write port and an asynchronous read port.
// Contents are never reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, a programmable number of
// wait cycles, then a single-cycle response pulse with read data or error.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT4 = 4'(LATENCY);

   if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be within 0..15");
   end
   if (DEPTH_WORDS < 4 || DEPTH_WORDS > 1024 ||
       (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("mem_responder: DEPTH_WORDS must be a power of two within 4..1024");
   end

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic              req_ready_q;
   logic              busy_q;
   logic              resp_valid_q;

   logic [29:0]       word_idx_w;
   logic              err_w;
   logic              arr_we_w;
   logic [WORD_W-1:0] arr_rdata_w;

   assign word_idx_w = word_index(addr_q);
   assign err_w      = (addr_q[1:0] != 2'b00) || (word_idx_w >= 30'(DEPTH_WORDS));
   // The write lands on the edge that leaves RESP; a reset before then drops it.
   assign arr_we_w   = (state_q == RESP) && we_q && !err_w;

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we_w),
      .waddr_i (word_idx_w[AW-1:0]),
      .wdata_i (wdata_q),
      .raddr_i (word_idx_w[AW-1:0]),
      .rdata_o (arr_rdata_w)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q        <= req_we;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  cnt_q       <= LAT4;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (LATENCY == 0) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
               end
            end
            RESP: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               busy_q       <= 1'b0;
            end
            default: begin
               state_q      <= IDLE;
               cnt_q        <= '0;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign busy       = busy_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_valid_q && err_w;
   assign resp_rdata = (resp_valid_q && !we_q && !err_w) ? arr_rdata_w : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 0, 3) driven by directed
// and random requests, checked against a word-array model and cycle timing.
module tb_mem_responder;

   localparam int DEPTH = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_n      [3];
   logic        req_valid  [3];
   logic        req_ready  [3];
   logic        req_we     [3];
   logic [31:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic        resp_valid [3];
   logic [31:0] resp_rdata [3];
   logic        resp_err   [3];
   logic        busy       [3];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         mem_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     ((gi == 0) ? 2 : ((gi == 1) ? 0 : 3))
         ) u_dut (
            .clk        (clk),
            .reset_n    (rst_n[gi]),
            .req_valid  (req_valid[gi]),
            .req_ready  (req_ready[gi]),
            .req_we     (req_we[gi]),
            .req_addr   (req_addr[gi]),
            .req_wdata  (req_wdata[gi]),
            .resp_valid (resp_valid[gi]),
            .resp_rdata (resp_rdata[gi]),
            .resp_err   (resp_err[gi]),
            .busy       (busy[gi])
         );
      end
   endgenerate

   int checks = 0;
   int errors = 0;
   int last_acc [3] = '{-1, -1, -1};

   // Reference memory per instance: contents plus a written-yet flag.
   logic [31:0] mdl    [3][DEPTH];
   bit          mknown [3][DEPTH];

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
   endfunction

   function automatic logic [31:0] gen_addr();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      if (r == 1) return 32'($urandom_range(64, 1000)) << 2;
      return 32'($urandom_range(0, 63)) << 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_junk(input int k);
      req_valid[k] = 1'b1;
      req_we[k]    = 1'b1;
      req_addr[k]  = 32'($urandom_range(0, 63)) << 2;
      req_wdata[k] = $urandom;
   endtask

   task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit junk, output logic [31:0] rd);
      int  lat;
      int  n;
      bit  err;
      int  idx;
      lat = lat_of(k);
      n   = 0;
      while (req_ready[k] !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_idle", 32'(req_ready[k]), 32'd1);
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      @(posedge clk); #1;
      if (junk && last_acc[k] >= 0) chk("accept_gap", 32'(cyc - last_acc[k]), 32'(lat + 2));
      last_acc[k] = cyc;
      err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
      idx = int'(addr[7:2]);
      for (int i = 0; i < lat; i++) begin
         if (junk) drive_junk(k); else req_valid[k] = 1'b0;
         chk("wait_resp_valid", 32'(resp_valid[k]), 32'd0);
         chk("wait_busy", 32'(busy[k]), 32'd1);
         chk("wait_ready", 32'(req_ready[k]), 32'd0);
         @(posedge clk); #1;
      end
      if (junk) drive_junk(k); else req_valid[k] = 1'b0;
      chk("resp_valid", 32'(resp_valid[k]), 32'd1);
      chk("resp_busy", 32'(busy[k]), 32'd1);
      chk("resp_ready", 32'(req_ready[k]), 32'd0);
      chk("resp_err", 32'(resp_err[k]), 32'(err));
      rd = resp_rdata[k];
      if (we || err) chk("resp_rdata_zero", rd, 32'd0);
      else if (mknown[k][idx]) chk("resp_rdata", rd, mdl[k][idx]);
      $display("txn inst=%0d we=%0d addr=%h wdata=%h err=%0d rdata=%h cyc=%0d",
               k, we, addr, wdata, resp_err[k], rd, cyc);
      @(posedge clk); #1;
      chk("post_resp_valid", 32'(resp_valid[k]), 32'd0);
      chk("post_busy", 32'(busy[k]), 32'd0);
      chk("post_ready", 32'(req_ready[k]), 32'd1);
      chk("post_rdata", resp_rdata[k], 32'd0);
      chk("post_err", 32'(resp_err[k]), 32'd0);
      if (we && !err) begin
         mdl[k][idx]    = wdata;
         mknown[k][idx] = 1'b1;
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      int          k;

      for (int i = 0; i < 3; i++) begin
         rst_n[i]     = 1'b0;
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_ready", 32'(req_ready[i]), 32'd1);
         chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
         chk("rst_rdata", resp_rdata[i], 32'd0);
         chk("rst_err", 32'(resp_err[i]), 32'd0);
         chk("rst_busy", 32'(busy[i]), 32'd0);
      end
      #2;
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a write's wait phase must drop the write.
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 32'h10;
      req_wdata[0] = 32'hDEADBEEF;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      chk("midwait_busy", 32'(busy[0]), 32'd1);
      #1 rst_n[0] = 1'b0;
      #1;
      chk("async_rst_ready", 32'(req_ready[0]), 32'd1);
      chk("async_rst_resp_valid", 32'(resp_valid[0]), 32'd0);
      chk("async_rst_rdata", resp_rdata[0], 32'd0);
      chk("async_rst_err", 32'(resp_err[0]), 32'd0);
      chk("async_rst_busy", 32'(busy[0]), 32'd0);
      @(posedge clk); #2;
      rst_n[0] = 1'b1;
      @(posedge clk); #1;
      do_req(0, 1'b0, 32'h10, 32'h0, 1'b0, rd);
      checks++;
      assert (rd !== 32'hDEADBEEF) else begin
         errors++;
         $error("FAIL discarded_write: observed=%h expected=not DEADBEEF", rd);
      end

      // LATENCY=2 write then read back, plus error cases and the last word.
      do_req(0, 1'b1, 32'h4, 32'hCAFEF00D, 1'b0, rd);
      do_req(0, 1'b0, 32'h4, 32'h0, 1'b0, rd);
      do_req(0, 1'b1, 32'h0, 32'h12345678, 1'b0, rd);
      do_req(0, 1'b0, 32'h6, 32'h0, 1'b0, rd);
      do_req(0, 1'b1, 32'h100, 32'hBAADF00D, 1'b0, rd);
      do_req(0, 1'b0, 32'h0, 32'h0, 1'b0, rd);
      do_req(0, 1'b1, 32'hFC, 32'h0BADCAFE, 1'b0, rd);
      do_req(0, 1'b0, 32'hFC, 32'h0, 1'b0, rd);

      // LATENCY=0: response in the cycle after acceptance.
      do_req(1, 1'b1, 32'h20, 32'hA5A5_0001, 1'b0, rd);
      do_req(1, 1'b0, 32'h20, 32'h0, 1'b0, rd);
      do_req(1, 1'b0, 32'h101, 32'h0, 1'b0, rd);

      // LATENCY=3 with req_valid held high and changing addresses throughout.
      last_acc[2] = -1;
      for (int i = 0; i < 8; i++) begin
         a = 32'($urandom_range(0, 63)) << 2;
         do_req(2, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, rd);
      end
      req_valid[2] = 1'b0;
      @(posedge clk); #1;

      // Random traffic across all instances.
      for (int i = 0; i < 40; i++) begin
         k = int'($urandom_range(0, 2));
         do_req(k, 1'($urandom_range(0, 1)), gen_addr(), $urandom, 1'b0, rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
